fetch_stage: RTL

Instruction-fetch stage of the RV32I pipeline: owns the PC register, the instruction-memory request handshake and the IF/ID pipeline register. It is the consumer of the hazard detection unit's stall outputs (`PCWrite`, `IFIDWrite`). When stalled it freezes the PC and IF/ID, and holds any in-flight fetch in a one-entry skid buffer. Branch redirects from EX flush IF/ID to a bubble and restart fetch at the target.

---
 rtl/fetch_stage_pkg.sv | 20 ++
 rtl/fetch_stage.sv | 119 +++++++++++
 2 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the RV32I fetch stage: defaults and fetch FSM encodings.
package fetch_stage_pkg;

    // addi x0, x0, 0
    localparam logic [31:0] DefaultNopInstr = 32'h0000_0013;
    localparam logic [31:0] DefaultResetPc  = 32'h0000_0000;

    typedef enum logic [1:0] {
        StIdle = 2'd0,  // reset state, no request yet
        StWait = 2'd1,  // request outstanding on the current path
        StFull = 2'd2,  // skid holds a fetched instruction, no request
        StDrop = 2'd3   // outstanding request belongs to a squashed path
    } fetch_state_e;

    // Clear the byte offset of a redirect address.
    function automatic logic [31:0] wordAlign(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, imem request handshake, one-entry skid buffer
// and the IF/ID pipeline register. Redirects from EX override stalls.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DefaultResetPc,
    parameter logic [31:0] NOP_INSTR = DefaultNopInstr
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCWrite,
    input  logic        IFIDWrite,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IFID_PC,
    output logic [31:0] IFID_Instr,
    output logic        IFID_Valid
);

    fetch_state_e state_q;
    logic [31:0]  pc_q;
    logic [31:0]  fetch_addr_q;
    logic [31:0]  skid_q;
    logic         skid_valid_q;

    logic         advance;
    logic         complete;
    logic [31:0]  target;
    logic [31:0]  pc_plus4;

    // A mismatched PCWrite/IFIDWrite pair is treated as a stall.
    assign advance  = PCWrite & IFIDWrite;
    assign complete = imem_req & imem_ready;
    assign target   = wordAlign(branch_target);
    assign pc_plus4 = pc_q + 32'd4;

    // Request is decoded from the state so reset drops it without a clock edge.
    assign imem_req  = (state_q == StWait) || (state_q == StDrop);
    assign imem_addr = fetch_addr_q;

    // Fetch FSM, PC, skid buffer and IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            fetch_addr_q <= RESET_PC;
            skid_q       <= NOP_INSTR;
            skid_valid_q <= 1'b0;
            IFID_PC      <= 32'd0;
            IFID_Instr   <= NOP_INSTR;
            IFID_Valid   <= 1'b0;
        end else if (branch_taken) begin
            pc_q <= target;
            if (state_q == StDrop) begin
                // Squashed request still in flight; it will restart from the new PC.
                state_q <= StDrop;
            end else begin
                IFID_PC      <= target;
                IFID_Instr   <= NOP_INSTR;
                IFID_Valid   <= 1'b0;
                skid_valid_q <= 1'b0;
                if (state_q == StWait && !complete) begin
                    // Address must stay stable until the stale request completes.
                    state_q <= StDrop;
                end else begin
                    fetch_addr_q <= target;
                    state_q      <= StWait;
                end
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    fetch_addr_q <= pc_q;
                    state_q      <= StWait;
                end
                StWait: begin
                    if (complete && advance) begin
                        IFID_PC      <= fetch_addr_q;
                        IFID_Instr   <= imem_rdata;
                        IFID_Valid   <= 1'b1;
                        pc_q         <= pc_plus4;
                        fetch_addr_q <= pc_plus4;
                    end else if (complete) begin
                        skid_q       <= imem_rdata;
                        skid_valid_q <= 1'b1;
                        state_q      <= StFull;
                    end else if (advance) begin
                        IFID_PC    <= pc_q;
                        IFID_Instr <= NOP_INSTR;
                        IFID_Valid <= 1'b0;
                    end
                end
                StFull: begin
                    if (advance) begin
                        IFID_PC      <= pc_q;
                        IFID_Instr   <= skid_q;
                        IFID_Valid   <= skid_valid_q;
                        skid_valid_q <= 1'b0;
                        pc_q         <= pc_plus4;
                        fetch_addr_q <= pc_plus4;
                        state_q      <= StWait;
                    end
                end
                StDrop: begin
                    if (complete) begin
                        fetch_addr_q <= pc_q;
                        state_q      <= StWait;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
